// File: rtl/ntt_k2_writeback_if.sv
// Bus bundle between the k2 AGU / butterfly side and the writeback block.
interface ntt_k2_writeback_if #(
  parameter int unsigned D_WIDTH    = 10,
  parameter int unsigned DATA_WIDTH = 64
);
  logic                  wb_start;
  logic [D_WIDTH-1:0]    pair_count;
  logic                  ord_valid;
  logic [D_WIDTH-1:0]    ord0;
  logic [D_WIDTH-1:0]    ord1;
  logic                  bf_valid;
  logic [DATA_WIDTH-1:0] bf_y0;
  logic [DATA_WIDTH-1:0] bf_y1;
  logic                  mem_we;
  logic [D_WIDTH-1:0]    mem_addr0;
  logic [D_WIDTH-1:0]    mem_addr1;
  logic [DATA_WIDTH-1:0] mem_wdata0;
  logic [DATA_WIDTH-1:0] mem_wdata1;
  logic                  wb_busy;
  logic                  wb_done;
  logic                  err_ovf;
  logic                  err_unf;
  logic                  err_addr;

  modport master (
    output wb_start, pair_count, ord_valid, ord0, ord1, bf_valid, bf_y0, bf_y1,
    input  mem_we, mem_addr0, mem_addr1, mem_wdata0, mem_wdata1,
           wb_busy, wb_done, err_ovf, err_unf, err_addr
  );

  modport slave (
    input  wb_start, pair_count, ord_valid, ord0, ord1, bf_valid, bf_y0, bf_y1,
    output mem_we, mem_addr0, mem_addr1, mem_wdata0, mem_wdata1,
           wb_busy, wb_done, err_ovf, err_unf, err_addr
  );
endinterface

// File: rtl/ntt_k2_writeback.sv
// k2 writeback: queues AGU address pairs, pairs them with butterfly results, writes both banks.
// Optional address-form check on pushes is built when WB_ADDR_CHECK_EN is defined.
module ntt_k2_writeback #(
  parameter int unsigned D_WIDTH    = 10,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input logic               clk,
  input logic               rst,
  ntt_k2_writeback_if.slave bus
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned EW = 2 * D_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t state, state_nxt;
  logic   busy_q, done_q, busy_nxt, done_nxt;

  logic [EW-1:0]         fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [EW-1:0]         head;
  logic                  empty, full, push, pop, run, start_any, cnt_last;
  logic [D_WIDTH-1:0]    pc_q, cnt_q;
  logic                  we_q, ovf_q, unf_q, addr_err_q;
  logic [D_WIDTH-1:0]    addr0_q, addr1_q;
  logic [DATA_WIDTH-1:0] wdata0_q, wdata1_q;

  assign run       = (state == S_RUN);
  assign start_any = (state == S_IDLE) && bus.wb_start;
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  // No bypass: an empty FIFO never pops, even with a push in the same cycle.
  assign pop       = run && bus.bf_valid && !empty;
  assign push      = run && bus.ord_valid && (!full || pop);
  assign cnt_last  = (cnt_q == pc_q - D_WIDTH'(1));
  assign head      = fifo_mem[rd_ptr[AW-1:0]];

  // State register, also holding the registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_q <= busy_nxt;
      done_q <= done_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (bus.wb_start) state_nxt = (bus.pair_count != '0) ? S_RUN : S_DONE;
      S_RUN:  if (pop && cnt_last) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Status outputs decoded from the next state so they register alongside it
  always_comb begin
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    if (state_nxt == S_RUN)  busy_nxt = 1'b1;
    if (state_nxt == S_DONE) done_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= {bus.ord0, bus.ord1};
  end

  // FIFO pointers; flushed on every accepted start
  always_ff @(posedge clk) begin
    if (rst || start_any) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= '0;
      cnt_q <= '0;
    end else if (start_any) begin
      pc_q  <= bus.pair_count;
      cnt_q <= '0;
    end else if (pop && !cnt_last) begin
      cnt_q <= cnt_q + D_WIDTH'(1);
    end
  end

  // Registered write port, one cycle after the pop
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q     <= 1'b0;
      addr0_q  <= '0;
      addr1_q  <= '0;
      wdata0_q <= '0;
      wdata1_q <= '0;
    end else begin
      we_q <= pop;
      if (pop) begin
        addr0_q  <= head[EW-1:D_WIDTH];
        addr1_q  <= head[D_WIDTH-1:0];
        wdata0_q <= bus.bf_y0;
        wdata1_q <= bus.bf_y1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || start_any) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (run && bus.ord_valid && full && !pop) ovf_q <= 1'b1;
      if (run && bus.bf_valid && empty)         unf_q <= 1'b1;
    end
  end

`ifdef WB_ADDR_CHECK_EN
  // Pairs must be (even, even+1); a bad pair is flagged but still written
  always_ff @(posedge clk) begin
    if (rst || start_any) begin
      addr_err_q <= 1'b0;
    end else if (push && (bus.ord0[0] || (bus.ord1 != bus.ord0 + D_WIDTH'(1)))) begin
      addr_err_q <= 1'b1;
    end
  end
`else
  assign addr_err_q = 1'b0;
`endif

  assign bus.mem_we     = we_q;
  assign bus.mem_addr0  = addr0_q;
  assign bus.mem_addr1  = addr1_q;
  assign bus.mem_wdata0 = wdata0_q;
  assign bus.mem_wdata1 = wdata1_q;
  assign bus.wb_busy    = busy_q;
  assign bus.wb_done    = done_q;
  assign bus.err_ovf    = ovf_q;
  assign bus.err_unf    = unf_q;
  assign bus.err_addr   = addr_err_q;
endmodule

// File: tb/tb_ntt_k2_writeback.sv
// Directed bench for ntt_k2_writeback: vector table plus hand-written multi-cycle sequences.
module tb_ntt_k2_writeback;
  localparam int unsigned DW = 10;
  localparam int unsigned XW = 64;
`ifdef WB_ADDR_CHECK_EN
  localparam bit ADDR_CHK = 1'b1;
`else
  localparam bit ADDR_CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  ntt_k2_writeback_if #(.D_WIDTH(DW), .DATA_WIDTH(XW)) bus ();
  ntt_k2_writeback #(.D_WIDTH(DW), .DATA_WIDTH(XW), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    logic          start;
    logic [DW-1:0] pc;
    logic          ov;
    logic [DW-1:0] o0, o1;
    logic          bv;
    logic [XW-1:0] y0, y1;
    logic          we;
    logic [DW-1:0] a0, a1;
    logic [XW-1:0] d0, d1;
    logic          busy, done, ovf, unf;
  } vec_t;

  vec_t vt [22];

  function automatic vec_t v(logic start, int pc, logic ov, int o0, int o1,
                             logic bv, logic [XW-1:0] y0, logic [XW-1:0] y1,
                             logic we, int a0, int a1, logic [XW-1:0] d0, logic [XW-1:0] d1,
                             logic busy, logic done, logic ovf, logic unf);
    vec_t r;
    r.start = start; r.pc = DW'(pc); r.ov = ov; r.o0 = DW'(o0); r.o1 = DW'(o1);
    r.bv = bv; r.y0 = y0; r.y1 = y1; r.we = we; r.a0 = DW'(a0); r.a1 = DW'(a1);
    r.d0 = d0; r.d1 = d1; r.busy = busy; r.done = done; r.ovf = ovf; r.unf = unf;
    return r;
  endfunction

  task automatic chk(input string name, input logic [XW-1:0] act, input logic [XW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic start, input int pc, input logic ov, input int o0, input int o1,
                       input logic bv, input logic [XW-1:0] y0, input logic [XW-1:0] y1);
    bus.wb_start = start; bus.pair_count = DW'(pc);
    bus.ord_valid = ov; bus.ord0 = DW'(o0); bus.ord1 = DW'(o1);
    bus.bf_valid = bv; bus.bf_y0 = y0; bus.bf_y1 = y1;
  endtask

  task automatic idle_in();
    drive(0, 0, 0, 0, 0, 0, '0, '0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string n, input int a0, input int a1,
                        input logic [XW-1:0] d0, input logic [XW-1:0] d1);
    chk({n, ".we"}, XW'(bus.mem_we), XW'(1));
    chk({n, ".a0"}, XW'(bus.mem_addr0), XW'(a0));
    chk({n, ".a1"}, XW'(bus.mem_addr1), XW'(a1));
    chk({n, ".d0"}, bus.mem_wdata0, d0);
    chk({n, ".d1"}, bus.mem_wdata1, d1);
  endtask

  task automatic chk_all_zero(input string n);
    chk({n, ".we"},   XW'(bus.mem_we), '0);
    chk({n, ".a0"},   XW'(bus.mem_addr0), '0);
    chk({n, ".a1"},   XW'(bus.mem_addr1), '0);
    chk({n, ".d0"},   bus.mem_wdata0, '0);
    chk({n, ".d1"},   bus.mem_wdata1, '0);
    chk({n, ".busy"}, XW'(bus.wb_busy), '0);
    chk({n, ".done"}, XW'(bus.wb_done), '0);
    chk({n, ".ovf"},  XW'(bus.err_ovf), '0);
    chk({n, ".unf"},  XW'(bus.err_unf), '0);
    chk({n, ".eaddr"},XW'(bus.err_addr), '0);
  endtask

  initial begin
    // Nominal pass, butterfly results 3 cycles behind the addresses
    vt[0]  = v(1,4, 0,0,0,   0,0,0,         0,0,0,0,0,               1,0,0,0);
    vt[1]  = v(0,0, 1,0,1,   0,0,0,         0,0,0,0,0,               1,0,0,0);
    vt[2]  = v(0,0, 1,4,5,   0,0,0,         0,0,0,0,0,               1,0,0,0);
    vt[3]  = v(0,0, 1,2,3,   0,0,0,         0,0,0,0,0,               1,0,0,0);
    vt[4]  = v(0,0, 1,6,7,   1,'hA0,'hB0,   1,0,1,'hA0,'hB0,         1,0,0,0);
    vt[5]  = v(0,0, 0,0,0,   1,'hA1,'hB1,   1,4,5,'hA1,'hB1,         1,0,0,0);
    vt[6]  = v(0,0, 0,0,0,   1,'hA2,'hB2,   1,2,3,'hA2,'hB2,         1,0,0,0);
    vt[7]  = v(0,0, 0,0,0,   1,'hA3,'hB3,   1,6,7,'hA3,'hB3,         0,1,0,0);
    vt[8]  = v(0,0, 0,0,0,   0,0,0,         0,6,7,'hA3,'hB3,         0,0,0,0);
    // Ignore rules in IDLE, zero-length pass, start ignored in DONE
    vt[9]  = v(0,0, 1,20,21, 1,1,2,         0,6,7,'hA3,'hB3,         0,0,0,0);
    vt[10] = v(1,0, 0,0,0,   0,0,0,         0,6,7,'hA3,'hB3,         0,1,0,0);
    vt[11] = v(1,3, 0,0,0,   0,0,0,         0,6,7,'hA3,'hB3,         0,0,0,0);
    // Underflow then a normal single pair
    vt[12] = v(1,1, 0,0,0,   0,0,0,         0,6,7,'hA3,'hB3,         1,0,0,0);
    vt[13] = v(0,0, 0,0,0,   1,'h11,'h22,   0,6,7,'hA3,'hB3,         1,0,0,1);
    vt[14] = v(0,0, 1,10,11, 0,0,0,         0,6,7,'hA3,'hB3,         1,0,0,1);
    vt[15] = v(0,0, 0,0,0,   1,'h55,'h66,   1,10,11,'h55,'h66,       0,1,0,1);
    vt[16] = v(0,0, 0,0,0,   0,0,0,         0,10,11,'h55,'h66,       0,0,0,1);
    // New start clears errors; start during RUN is ignored
    vt[17] = v(1,2, 0,0,0,   0,0,0,         0,10,11,'h55,'h66,       1,0,0,0);
    vt[18] = v(1,7, 1,12,13, 0,0,0,         0,10,11,'h55,'h66,       1,0,0,0);
    vt[19] = v(0,0, 1,14,15, 1,1,2,         1,12,13,1,2,             1,0,0,0);
    vt[20] = v(0,0, 0,0,0,   1,3,4,         1,14,15,3,4,             0,1,0,0);
    vt[21] = v(0,0, 0,0,0,   0,0,0,         0,14,15,3,4,             0,0,0,0);

    rst = 1'b1;
    idle_in();
    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 22; i++) begin
      string n;
      n = $sformatf("v%0d", i);
      drive(vt[i].start, int'(vt[i].pc), vt[i].ov, int'(vt[i].o0), int'(vt[i].o1),
            vt[i].bv, vt[i].y0, vt[i].y1);
      tick();
      chk({n, ".we"},   XW'(bus.mem_we),    XW'(vt[i].we));
      chk({n, ".a0"},   XW'(bus.mem_addr0), XW'(vt[i].a0));
      chk({n, ".a1"},   XW'(bus.mem_addr1), XW'(vt[i].a1));
      chk({n, ".d0"},   bus.mem_wdata0,     vt[i].d0);
      chk({n, ".d1"},   bus.mem_wdata1,     vt[i].d1);
      chk({n, ".busy"}, XW'(bus.wb_busy),   XW'(vt[i].busy));
      chk({n, ".done"}, XW'(bus.wb_done),   XW'(vt[i].done));
      chk({n, ".ovf"},  XW'(bus.err_ovf),   XW'(vt[i].ovf));
      chk({n, ".unf"},  XW'(bus.err_unf),   XW'(vt[i].unf));
      chk({n, ".eaddr"},XW'(bus.err_addr),  '0);
    end

    // Overflow: 9 pushes into 8 entries, then 8 pops without finishing pair_count=9
    drive(1, 9, 0, 0, 0, 0, '0, '0);
    tick();
    for (int i = 0; i < 9; i++) begin
      drive(0, 0, 1, 32 + 2 * i, 33 + 2 * i, 0, '0, '0);
      tick();
      chk($sformatf("ovf.push%0d", i), XW'(bus.err_ovf), XW'(i == 8));
    end
    for (int k = 0; k < 8; k++) begin
      drive(0, 0, 0, 0, 0, 1, XW'(256 + k), XW'(512 + k));
      tick();
      chk_wr($sformatf("ovf.pop%0d", k), 32 + 2 * k, 33 + 2 * k, XW'(256 + k), XW'(512 + k));
      chk($sformatf("ovf.pop%0d.done", k), XW'(bus.wb_done), '0);
    end
    idle_in();
    tick();
    chk("ovf.after.we", XW'(bus.mem_we), '0);
    chk("ovf.after.busy", XW'(bus.wb_busy), XW'(1));
    chk("ovf.after.sticky", XW'(bus.err_ovf), XW'(1));

    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all_zero("rst1");

    // Reset mid-pass after 2 of 4 writes, then a fresh 2-pair pass
    drive(1, 4, 0, 0, 0, 0, '0, '0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 40 + 2 * i, 41 + 2 * i, 0, '0, '0);
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 0, 0, 0, 1, XW'('hC0 + k), XW'('hD0 + k));
      tick();
      chk_wr($sformatf("mid.pop%0d", k), 40 + 2 * k, 41 + 2 * k, XW'('hC0 + k), XW'('hD0 + k));
    end
    idle_in();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all_zero("rst2");
    drive(1, 2, 0, 0, 0, 0, '0, '0);
    tick();
    chk("fresh.busy", XW'(bus.wb_busy), XW'(1));
    drive(0, 0, 1, 50, 51, 0, '0, '0);
    tick();
    drive(0, 0, 1, 52, 53, 1, XW'('h71), XW'('h72));
    tick();
    chk_wr("fresh.w0", 50, 51, XW'('h71), XW'('h72));
    drive(0, 0, 0, 0, 0, 1, XW'('h73), XW'('h74));
    tick();
    chk_wr("fresh.w1", 52, 53, XW'('h73), XW'('h74));
    chk("fresh.done", XW'(bus.wb_done), XW'(1));
    idle_in();
    tick();
    chk("fresh.idle.done", XW'(bus.wb_done), '0);
    chk("fresh.idle.busy", XW'(bus.wb_busy), '0);

    // Address-form check: (8,9) is well formed, (3,4) is not but is still written
    drive(1, 2, 0, 0, 0, 0, '0, '0);
    tick();
    drive(0, 0, 1, 8, 9, 0, '0, '0);
    tick();
    chk("addr.good", XW'(bus.err_addr), '0);
    drive(0, 0, 1, 3, 4, 0, '0, '0);
    tick();
    chk("addr.bad", XW'(bus.err_addr), XW'(ADDR_CHK));
    drive(0, 0, 0, 0, 0, 1, XW'(7), XW'(8));
    tick();
    chk_wr("addr.w0", 8, 9, XW'(7), XW'(8));
    drive(0, 0, 0, 0, 0, 1, XW'(5), XW'(6));
    tick();
    chk_wr("addr.w1", 3, 4, XW'(5), XW'(6));
    chk("addr.sticky", XW'(bus.err_addr), XW'(ADDR_CHK));
    chk("addr.done", XW'(bus.wb_done), XW'(1));
    idle_in();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
